// File: rtl/key_click_decoder_if.sv
// Key click decoder bundle: press pulses in, decoded click events out.
// Master is the press source and event sink; slave is the decoder.
interface key_click_decoder_if;
  logic       key_flag;
  logic       single_flag;
  logic       double_flag;
  logic       triple_flag;
  logic       busy;
  logic [7:0] ev_cnt;

  modport master (
    output key_flag,
    input  single_flag,
    input  double_flag,
    input  triple_flag,
    input  busy,
    input  ev_cnt
  );

  modport slave (
    input  key_flag,
    output single_flag,
    output double_flag,
    output triple_flag,
    output busy,
    output ev_cnt
  );
endinterface

// File: rtl/key_click_decoder.sv
// Decodes single/double/triple key clicks within a per-press time window.
// Each press restarts the window; a third press decodes immediately.
module key_click_decoder #(
  parameter logic [23:0] CNT_WIN = 24'd14_999_999
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  key_click_decoder_if.slave   kc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    WAIT2 = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [23:0] cnt_q;
  logic [23:0] cnt_d;
  logic        single_q;
  logic        double_q;
  logic        triple_q;
  logic        single_d;
  logic        double_d;
  logic        triple_d;
  logic [7:0]  ev_q;
  logic        timeout;
  logic        pulse;

  assign timeout = (cnt_q == CNT_WIN);
  assign pulse   = single_q | double_q | triple_q;

  // A press always wins over a coincident window expiry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    single_d = 1'b0;
    double_d = 1'b0;
    triple_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (kc.key_flag) begin
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (kc.key_flag) begin
          state_d = WAIT2;
        end else if (timeout) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      WAIT2: begin
        if (kc.key_flag) begin
          state_d  = IDLE;
          triple_d = 1'b1;
        end else if (timeout) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      triple_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      triple_q <= triple_d;
    end
  end

  // Counts while the pulse is visible, so it lands one edge later.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ev_q <= '0;
    end else if (pulse) begin
      ev_q <= ev_q + 8'd1;
    end
  end

  assign kc.single_flag = single_q;
  assign kc.double_flag = double_q;
  assign kc.triple_flag = triple_q;
  assign kc.busy        = (state_q != IDLE);
  assign kc.ev_cnt      = ev_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// Self-checking bench for key_click_decoder against a timestamp-based model.
// Directed click patterns, window boundaries, reset abort, wrap and random.
module tb_key_click_decoder;

  localparam int WIN = 24;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   t;

  key_click_decoder_if kc ();

  key_click_decoder #(
    .CNT_WIN(24'd24)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .kc     (kc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: a sequence is a list of press timestamps; it closes on the
  // third press or when WIN+1 edges pass since the last press.
  bit m_open;
  int m_presses;
  int m_last;
  bit m_s;
  bit m_d;
  bit m_t;
  int m_ev;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at edge %0d",
               tag, got, exp, t);
    end
  endtask

  function automatic void model_step(input bit k, input bit r);
    if (r) begin
      m_open = 0;
      m_s    = 0;
      m_d    = 0;
      m_t    = 0;
      m_ev   = 0;
      return;
    end
    if (m_s || m_d || m_t) m_ev = (m_ev + 1) % 256;
    m_s = 0;
    m_d = 0;
    m_t = 0;
    if (m_open) begin
      if (k) begin
        m_presses++;
        m_last = t;
        if (m_presses == 3) begin
          m_t    = 1;
          m_open = 0;
        end
      end else if (t - m_last == WIN + 1) begin
        if (m_presses == 1) m_s = 1;
        else m_d = 1;
        m_open = 0;
      end
    end else if (k) begin
      m_open    = 1;
      m_presses = 1;
      m_last    = t;
    end
  endfunction

  task automatic tick(input bit k, input bit r);
    kc.key_flag = k;
    rst         = r;
    @(posedge clk);
    t++;
    model_step(k, r);
    #1;
    check("single", {31'd0, kc.single_flag}, {31'd0, m_s});
    check("double", {31'd0, kc.double_flag}, {31'd0, m_d});
    check("triple", {31'd0, kc.triple_flag}, {31'd0, m_t});
    check("busy",   {31'd0, kc.busy},        {31'd0, m_open});
    check("ev_cnt", {24'd0, kc.ev_cnt},      m_ev[31:0]);
  endtask

  task automatic seq(input logic [127:0] mask, input int len);
    for (int c = 0; c < len; c++) tick(mask[c], 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
  endtask

  initial begin
    logic [127:0] m;
    n_chk       = 0;
    n_err       = 0;
    t           = 0;
    m_open      = 0;
    m_presses   = 0;
    m_last      = 0;
    m_s         = 0;
    m_d         = 0;
    m_t         = 0;
    m_ev        = 0;
    kc.key_flag = 1'b0;
    rst         = 1'b1;

    do_reset();
    check("reset_ev", {24'd0, kc.ev_cnt}, 32'd0);
    check("reset_busy", {31'd0, kc.busy}, 32'd0);

    m = '0; m[0] = 1'b1;
    seq(m, 40);
    check("single_ev", {24'd0, kc.ev_cnt}, 32'd1);

    m = '0; m[0] = 1'b1; m[10] = 1'b1;
    seq(m, 50);

    m = '0; m[0] = 1'b1; m[10] = 1'b1; m[20] = 1'b1;
    seq(m, 30);

    // Second press exactly as the window expires, then one edge later.
    m = '0; m[0] = 1'b1; m[25] = 1'b1;
    seq(m, 60);
    m = '0; m[0] = 1'b1; m[26] = 1'b1;
    seq(m, 60);

    // Press in the same cycle a triple pulse is visible.
    m = '0; m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b1;
    seq(m, 40);

    m = '0; m[0] = 1'b1;
    seq(m, 12);
    do_reset();
    seq('0, 30);
    check("abort_ev", {24'd0, kc.ev_cnt}, 32'd0);

    for (int i = 0; i < 256; i++) begin
      m = '0; m[0] = 1'b1;
      seq(m, 27);
    end
    check("wrap_ev", {24'd0, kc.ev_cnt}, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 9) == 0),
           ($urandom_range(0, 299) == 0));
    end
    seq('0, 30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
